// File: rtl/mac_acc_pkg.sv
// Shared definitions for the grouped MAC accumulator array: FSM encoding,
// default parameter values and the mode-to-group-size mapping.
package mac_acc_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_PART_W = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_MIN_W  = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int groupSize(input int mode);
    return 1 << mode;
  endfunction

endpackage

// File: rtl/mac_acc_combine.sv
// Combinational shift-add of lane partials into per-group contributions;
// every group size is built in parallel and the active mode selects one.
module mac_acc_combine
  import mac_acc_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int PART_W = DEF_PART_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int MIN_W  = DEF_MIN_W
) (
  input  logic [$clog2(LANES):0]    mode_i,
  input  logic [LANES*PART_W-1:0]   partials_i,
  output logic [LANES*ACC_W-1:0]    contrib_o
);

  localparam int LOG2L  = $clog2(LANES);
  localparam int MODE_W = LOG2L + 1;
  localparam int FLAT_W = LANES * ACC_W;

  logic [LOG2L:0][FLAT_W-1:0] byMode;

  for (genvar m = 0; m <= LOG2L; m++) begin : g_mode
    localparam int G  = groupSize(m);
    localparam int GW = G * ACC_W;
    for (genvar k = 0; k < LANES / G; k++) begin : g_grp
      logic [GW-1:0] sum;
      always_comb begin
        sum = '0;
        for (int j = 0; j < G; j++) begin
          sum = sum + (GW'(partials_i[(k*G+j)*PART_W +: PART_W]) << (j * MIN_W));
        end
      end
      assign byMode[m][k*GW +: GW] = sum;
    end
  end

  always_comb begin
    contrib_o = byMode[0];
    for (int m = 1; m <= LOG2L; m++) begin
      if (mode_i == MODE_W'(m)) begin
        contrib_o = byMode[m];
      end
    end
  end

endmodule

// File: rtl/mac_acc_array.sv
// Grouped MAC accumulator array with beat counter and auto-drain FSM.
// Define MAC_ACC_SAT_EN to make accumulate-mode group adds saturate instead of wrap.
module mac_acc_array
  import mac_acc_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int PART_W = DEF_PART_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int MIN_W  = DEF_MIN_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [$clog2(LANES):0]    cfg_mode,
  input  logic                      cfg_acc,
  input  logic [CNT_W-1:0]          cfg_len,
  input  logic [LANES*ACC_W-1:0]    cfg_init,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*PART_W-1:0]   partials,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACC_W-1:0]    out_data,
  output logic [LANES-1:0]          out_ovf,
  output logic                      idle
);

  localparam int LOG2L  = $clog2(LANES);
  localparam int MODE_W = LOG2L + 1;
  localparam int FLAT_W = LANES * ACC_W;

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                accMode_q, accMode_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FLAT_W-1:0]   init_q, init_d;
  logic [FLAT_W-1:0]   accum_q, accum_d;
  logic [LANES-1:0]    ovf_q, ovf_d;

  logic [FLAT_W-1:0]   contrib;
  logic [FLAT_W-1:0]   sumSel;
  logic [LANES-1:0]    carrySel;
  logic                modeOk;
  logic                lastBeat;

  mac_acc_combine #(
    .LANES  (LANES),
    .PART_W (PART_W),
    .ACC_W  (ACC_W),
    .MIN_W  (MIN_W)
  ) u_combine (
    .mode_i     (mode_q),
    .partials_i (partials),
    .contrib_o  (contrib)
  );

  logic [LOG2L:0][FLAT_W-1:0] sumByMode;
  logic [LOG2L:0][LANES-1:0]  carryByMode;

  // Carries are confined to each group by giving every group its own adder.
  for (genvar m = 0; m <= LOG2L; m++) begin : g_mode
    localparam int G  = groupSize(m);
    localparam int GW = G * ACC_W;
    for (genvar k = 0; k < LANES / G; k++) begin : g_grp
      logic [GW:0] raw;
      assign raw = {1'b0, accum_q[k*GW +: GW]} + {1'b0, contrib[k*GW +: GW]};
`ifdef MAC_ACC_SAT_EN
      assign sumByMode[m][k*GW +: GW] = raw[GW] ? {GW{1'b1}} : raw[GW-1:0];
`else
      assign sumByMode[m][k*GW +: GW] = raw[GW-1:0];
`endif
      assign carryByMode[m][k*G +: G] = {G{raw[GW]}};
    end
  end

  always_comb begin
    sumSel   = sumByMode[0];
    carrySel = carryByMode[0];
    for (int m = 1; m <= LOG2L; m++) begin
      if (mode_q == MODE_W'(m)) begin
        sumSel   = sumByMode[m];
        carrySel = carryByMode[m];
      end
    end
  end

  assign modeOk   = (cfg_mode <= MODE_W'(LOG2L));
  assign lastBeat = !accMode_q || (cnt_q == (len_q - CNT_W'(1)));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    accMode_d = accMode_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    init_d    = init_q;
    accum_d   = accum_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (cfg_we && !abort) begin
          mode_d    = modeOk ? cfg_mode : '0;
          accMode_d = cfg_acc;
          len_d     = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
          init_d    = cfg_init;
          accum_d   = cfg_init;
          cnt_d     = '0;
          ovf_d     = '0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          if (accMode_q) begin
            accum_d = sumSel;
            ovf_d   = ovf_q | carrySel;
          end else begin
            accum_d = contrib;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (lastBeat) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          accum_d = init_q;
          cnt_d   = '0;
          ovf_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      accMode_q <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      init_q    <= '0;
      accum_q   <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      accMode_q <= accMode_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      init_q    <= init_d;
      accum_q   <= accum_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign idle      = (state_q == IDLE);
  assign out_data  = accum_q;
  assign out_ovf   = ovf_q;

endmodule

// File: doc/mac_acc_array.md
Name: mac_acc_array

Overview:
- Parametrised successor to the 4-lane MAC accumulator block.
- N lanes of unsigned partial products are ganged into groups of 1, 2, 4, … lanes. Each group accumulates for a programmed number of beats, then presents its sum on a valid/ready output.
- Adds input/output handshakes, a beat counter with an auto-drain FSM, per-group overflow flags, and run-time reload of initial values.
- Sits between the multiplier array and the result writeback path.

Parameters:
- LANES, 4, lane count; power of two, at least 1.
- PART_W, 16, width of one partial product.
- ACC_W, 32, accumulator width per lane; at least PART_W.
- MIN_W, 8, shift step between adjacent lanes inside a group.
- CNT_W, 16, width of the beat-count field.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  configuration write strobe; accepted only in IDLE.
- cfg_mode  in  $clog2(LANES)+1  group size is 2**cfg_mode.
- cfg_acc  in  1  1 = accumulate; 0 = pass-through (multiply-only).
- cfg_len  in  CNT_W  beats per accumulation window; 0 is treated as 1.
- cfg_init  in  LANES*ACC_W  initial accumulator values; lane i occupies slice i.
- abort  in  1  synchronous return to IDLE.
- in_valid  in  1  partials valid.
- in_ready  out  1  block can accept a beat.
- partials  in  LANES*PART_W  lane i partial occupies slice i.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LANES*ACC_W  accumulator contents; lane i occupies slice i.
- out_ovf  out  LANES  sticky overflow flag, one bit per lane (group flag replicated on every lane of the group).
- idle  out  1  FSM is in IDLE.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE.
  - Accumulators, beat counter, config registers and out_ovf clear to 0.
  - in_ready=0, out_valid=0, idle=1.
  - Reset may assert mid-window; the partial result is discarded.
- FSM states:
  - IDLE: in_ready=0. On cfg_we, latch all cfg_* fields, load accumulators from cfg_init, clear the counter and out_ovf, and move to ACCUM.
  - ACCUM: in_ready=1. Each accepted beat (in_valid & in_ready) updates the accumulators and increments the counter. The beat where counter==len-1 moves to DRAIN next cycle.
  - DRAIN: in_ready=0, out_valid=1, out_data=accumulators. out_data is stable until out_ready.
  - On out_ready in DRAIN: reload accumulators from the latched init value, clear counter and out_ovf, return to ACCUM.
- Latency: out_valid asserts one cycle after the last beat is accepted.
- Grouping:
  - g = 2**cfg_mode. A cfg_mode giving g > LANES is latched as 0 (g=1).
  - Lanes [k*g, k*g+g-1] form group k.
  - The group value is the lanes concatenated with the lowest lane least significant; its width is g*ACC_W.
- Combine: the contribution of group k is the sum over j<g of partial[k*g+j] << (j*MIN_W), zero-extended to g*ACC_W.
- Accumulate mode: group_acc <= group_acc + contribution, modulo 2**(g*ACC_W). Carries never cross group boundaries.
- Pass-through mode: cfg_len is ignored and treated as 1. group_acc <= contribution, discarding the init value.
- Overflow: the carry-out of a group add sets that group's out_ovf bits (sticky until reload). The flag is meaningful in accumulate mode only; it stays 0 in pass mode.
- abort has priority over all other events in every state.
  - Next state is IDLE, out_valid drops, accumulators are held.
  - abort in IDLE has no effect.
- cfg_we outside IDLE is ignored. cfg_we together with abort: abort wins and cfg_we is ignored.
- A beat presented while in_ready=0 is not consumed; the producer holds it.

Optional Feature:
- Macro: MAC_ACC_SAT_EN.
- Defined: accumulate-mode adds saturate to all-ones of the group width instead of wrapping. out_ovf is still set on saturation.
- Undefined: adds wrap as described above.

Decomposition:
- Package mac_acc_pkg holds:
  - FSM state encoding (IDLE, ACCUM, DRAIN).
  - Mode-to-group-size function.
  - Default parameter constants.
- One sub-module, mac_acc_combine: a combinational shift-add of partials into per-group contributions, given cfg_mode.
- FSM and accumulator registers live in the top module.

Test Plan:
- LANES=4, cfg_mode=0, acc=1, len=3, init=0, partials all 5 for 3 beats -> out_valid one cycle after the 3rd beat; each lane reads 15; out_ovf=0.
- cfg_mode=1, acc=0, partial0=0x0001, partial1=0x0002 -> lanes {1,0} read 0x201 (64-bit group value); in_ready returns after out_ready.
- cfg_mode=2, acc=1, len=1, init lane0=0xFFFFFFFF, lanes1-3=0, partial0=1 -> lane0=0 and lane1=1 (carry crosses lanes inside the group); out_ovf=0.
- cfg_mode=0, init lane0=0xFFFFFFF0, partial0=0x20, len=1 -> lane0=0x10 and out_ovf[0]=1. With MAC_ACC_SAT_EN: lane0=0xFFFFFFFF and out_ovf[0]=1.
- Hold out_ready=0 for 5 cycles in DRAIN -> out_data and out_valid stable, in_ready=0. abort in DRAIN -> IDLE next cycle, idle=1.
- Assert rst_n low mid-ACCUM -> immediate IDLE with all outputs at reset values. A cfg_we issued during ACCUM is ignored (mode unchanged).
